// File: rtl/mips_cpu_data_memory.sv
// Word-organised data RAM for the Harvard MIPS CPU: combinational read, rising-edge write.
// Define MIPS_DMEM_PATTERN_INIT_EN to have reset load a per-word test pattern instead of zeros.
module mips_cpu_data_memory #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        clk_enable,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic        data_write,
    input  logic        data_read,
    input  logic        reset,
    output logic [31:0] data_readdata
);

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] index;
    logic                 addr_unused;

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign index       = data_address[ADDR_BITS+1:2];
    assign addr_unused = ^{data_address[31:ADDR_BITS+2], data_address[1:0]};

`ifdef MIPS_DMEM_PATTERN_INIT_EN
    function automatic logic [31:0] init_word(input logic [15:0] idx);
        return {16'h8000 | {1'b0, idx[14:0]}, idx};
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
`ifdef MIPS_DMEM_PATTERN_INIT_EN
                mem_q[k] <= init_word(16'(k));
`else
                mem_q[k] <= 32'h0000_0000;
`endif
            end
        end else if (clk_enable && data_write) begin
            mem_q[index] <= data_writedata;
        end
    end

    assign data_readdata = data_read ? mem_q[index] : 32'h0000_0000;

endmodule

// File: tb/tb_mips_cpu_data_memory.sv
// Directed-vector bench for mips_cpu_data_memory; expectations follow the reset init
// pattern selected by MIPS_DMEM_PATTERN_INIT_EN.
module tb_mips_cpu_data_memory;

    logic        clk = 1'b0;
    logic        clk_enable;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic        data_write;
    logic        data_read;
    logic        reset;
    logic [31:0] data_readdata;

    int n_vec = 0;
    int n_err = 0;

    mips_cpu_data_memory dut (
        .clk            (clk),
        .clk_enable     (clk_enable),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .data_write     (data_write),
        .data_read      (data_read),
        .reset          (reset),
        .data_readdata  (data_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int unsigned i);
`ifdef MIPS_DMEM_PATTERN_INIT_EN
        logic [15:0] w;
        w = 16'(i);
        return {16'h8000 | {1'b0, w[14:0]}, w};
`else
        return (i == 32'hFFFF_FFFF) ? 32'h1 : 32'h0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic wr, input logic rd, input logic en);
        data_address   = addr;
        data_writedata = wdata;
        data_write     = wr;
        data_read      = rd;
        clk_enable     = en;
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        drive(addr, 32'h0, 1'b0, 1'b1, 1'b1);
        check(tag, data_readdata, exp);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("rst_out_rd", data_readdata, init_val(0));
        next_edge();
        reset = 1'b0;
        #1;

        // Post-reset contents
        read_chk("init_0",    32'h0000_0000, init_val(0));
        read_chk("init_8",    32'h0000_0008, init_val(2));
        read_chk("init_4092", 32'h0000_0FFC, init_val(1023));

        // Write with same-cycle read: old value until the edge
        drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        check("wr_old_val", data_readdata, init_val(4));
        next_edge();
        data_write = 1'b0;
        #1;
        check("wr_new_val", data_readdata, 32'hDEAD_BEEF);
        read_chk("rd_0x11", 32'h0000_0011, 32'hDEAD_BEEF);
        read_chk("rd_0x13", 32'h0000_0013, 32'hDEAD_BEEF);
        read_chk("rd_0x14", 32'h0000_0014, init_val(5));

        // Writes gated by clk_enable; reads stay live
        drive(32'h0000_0020, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        next_edge();
        check("en0_no_wr", data_readdata, init_val(8));
        drive(32'h0000_0010, 32'h0, 1'b0, 1'b1, 1'b0);
        check("en0_rd_live", data_readdata, 32'hDEAD_BEEF);
        read_chk("en0_after", 32'h0000_0020, init_val(8));

        // data_read low forces zero output
        drive(32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rd_low_zero", data_readdata, 32'h0);

        // Address wrap
        drive(32'h0000_1000, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
        next_edge();
        data_write = 1'b0;
        read_chk("wrap_rd_0",    32'h0000_0000, 32'hCAFE_F00D);
        read_chk("wrap_rd_1000", 32'h0000_1000, 32'hCAFE_F00D);
        drive(32'hFFFF_FFFC, 32'h5555_AAAA, 1'b1, 1'b1, 1'b1);
        next_edge();
        data_write = 1'b0;
        read_chk("wrap_top", 32'h0000_0FFC, 32'h5555_AAAA);

        // Reset mid-cycle with a pending write
        drive(32'h0000_0030, 32'h1111_2222, 1'b1, 1'b1, 1'b1);
        check("pend_old", data_readdata, init_val(12));
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_30", data_readdata, init_val(12));
        data_address = 32'h0000_0010;
        #1;
        check("rst_async_10", data_readdata, init_val(4));
        data_address = 32'h0000_0030;
        next_edge();
        check("rst_blk_wr", data_readdata, init_val(12));
        data_write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        read_chk("post_rst_30",  32'h0000_0030, init_val(12));
        read_chk("post_rst_0",   32'h0000_0000, init_val(0));
        read_chk("post_rst_top", 32'h0000_0FFC, init_val(1023));

        // Normal write resumes after reset
        drive(32'h0000_0030, 32'h0BAD_CAFE, 1'b1, 1'b1, 1'b1);
        next_edge();
        data_write = 1'b0;
        read_chk("wr_after_rst", 32'h0000_0030, 32'h0BAD_CAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
